// File: rtl/data_mem_responder_if.sv
// Request/response channel between the core's load/store unit and the data memory.
// The master drives requests and accepts responses; the slave does the opposite.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_func3;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_func3, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_func3, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle RISC-V data memory slave: LB/LH/LW/LBU/LHU/SB/SH/SW with wait states,
// little-endian lanes and alignment/range/func3 error reporting.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);
    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] BYTES = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  f3_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    // With zero latency the access happens on the acceptance edge itself,
    // so the request fields are used directly instead of the latched copy.
    logic        a_wr;
    logic [31:0] a_addr, a_wdata;
    logic [2:0]  a_f3;
    always_comb begin
        if (state_q == IDLE) begin
            a_wr    = bus.req_write;
            a_addr  = bus.req_addr;
            a_wdata = bus.req_wdata;
            a_f3    = bus.req_func3;
        end else begin
            a_wr    = wr_q;
            a_addr  = addr_q;
            a_wdata = wdata_q;
            a_f3    = f3_q;
        end
    end

    logic          f3_bad, mis, oor, err;
    logic [AW-1:0] idx;
    logic [31:0]   rword, rshift, ld, wlane;
    logic [15:0]   half;
    logic [3:0]    be;
    logic          enter;

    always_comb begin
        f3_bad = a_wr ? (a_f3 > 3'b010)
                      : (a_f3 == 3'b011 || a_f3 == 3'b110 || a_f3 == 3'b111);
        mis    = (a_f3[1:0] == 2'b01 && a_addr[0])
              || (a_f3[1:0] == 2'b10 && a_addr[1:0] != 2'b00);
        oor    = {1'b0, a_addr} >= BYTES;
        err    = f3_bad || mis || oor;
        idx    = a_addr[AW+1:2];
        rword  = mem[idx];
        rshift = rword >> {a_addr[1:0], 3'b000};
        half   = a_addr[1] ? rword[31:16] : rword[15:0];
        case (a_f3)
            3'b000:  ld = {{24{rshift[7]}}, rshift[7:0]};
            3'b100:  ld = {24'd0, rshift[7:0]};
            3'b001:  ld = {{16{half[15]}}, half};
            3'b101:  ld = {16'd0, half};
            3'b010:  ld = rword;
            default: ld = 32'd0;
        endcase
        case (a_f3[1:0])
            2'b00: begin
                wlane = {4{a_wdata[7:0]}};
                be    = 4'b0001 << a_addr[1:0];
            end
            2'b01: begin
                wlane = {2{a_wdata[15:0]}};
                be    = a_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wlane = a_wdata;
                be    = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bus.req_ready  = (state_q == IDLE);
        bus.resp_valid = (state_q == RESP);
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            BUSY: begin
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        enter   = (state_d == RESP) && (state_q != RESP);
        rdata_d = rdata_q;
        err_d   = err_q;
        if (enter) begin
            err_d   = err;
            rdata_d = (err || a_wr) ? 32'd0 : ld;
        end
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.req_valid) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            f3_q    <= bus.req_func3;
        end
    end

    // Reset drops an in-flight store before it can reach the array.
    always_ff @(posedge clk) begin
        if (!rst && enter && a_wr && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 2 / depth 1024, LATENCY 0 / depth 16)
// checked against a byte-array reference model with directed and random traffic.
module tb_data_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          sel;
    logic        d_valid, d_write, d_rready;
    logic [31:0] d_addr, d_wdata;
    logic [2:0]  d_f3;

    data_mem_responder_if bus0 ();
    data_mem_responder_if bus1 ();

    assign bus0.req_valid  = d_valid && (sel == 0);
    assign bus0.req_write  = d_write;
    assign bus0.req_addr   = d_addr;
    assign bus0.req_func3  = d_f3;
    assign bus0.req_wdata  = d_wdata;
    assign bus0.resp_ready = d_rready && (sel == 0);
    assign bus1.req_valid  = d_valid && (sel == 1);
    assign bus1.req_write  = d_write;
    assign bus1.req_addr   = d_addr;
    assign bus1.req_func3  = d_f3;
    assign bus1.req_wdata  = d_wdata;
    assign bus1.resp_ready = d_rready && (sel == 1);

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(0)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    logic        o_rv, o_qr, o_err;
    logic [31:0] o_rd;
    assign o_rv  = (sel == 1) ? bus1.resp_valid : bus0.resp_valid;
    assign o_qr  = (sel == 1) ? bus1.req_ready  : bus0.req_ready;
    assign o_err = (sel == 1) ? bus1.resp_err   : bus0.resp_err;
    assign o_rd  = (sel == 1) ? bus1.resp_rdata : bus0.resp_rdata;

    int nchk = 0;
    int nerr = 0;

    logic [7:0] mb0 [4096];
    logic [7:0] mb1 [64];

    function automatic int lat(input int s);
        return (s == 1) ? 0 : 2;
    endfunction

    function automatic int dep(input int s);
        return (s == 1) ? 16 : 1024;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input int s, input logic wr, input logic [31:0] a,
                         input logic [2:0] f3, input logic [31:0] wd,
                         output logic [31:0] er, output logic ee);
        int     sz;
        bit     legal;
        longint v;
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz    = 1 << f3[1:0];
        ee    = !legal || (longint'(a) % sz != 0) || (longint'(a) >= 4 * dep(s));
        er    = 32'd0;
        if (!ee) begin
            if (wr) begin
                for (int i = 0; i < sz; i++) begin
                    if (s == 1) mb1[int'(a) + i] = wd[8*i +: 8];
                    else        mb0[int'(a) + i] = wd[8*i +: 8];
                end
            end else begin
                v = 0;
                for (int i = 0; i < sz; i++) begin
                    v = v | (longint'((s == 1) ? mb1[int'(a) + i] : mb0[int'(a) + i]) << (8 * i));
                end
                if (!f3[2] && v[8*sz-1]) v = v - (longint'(1) << (8 * sz));
                er = v[31:0];
            end
        end
    endtask

    task automatic xact(input int s, input logic wr, input logic [31:0] a,
                        input logic [2:0] f3, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd, output logic ee);
        logic [31:0] er;
        int n;
        model(s, wr, a, f3, wd, er, ee);
        sel = s;
        @(negedge clk);
        d_valid  = 1'b1;
        d_write  = wr;
        d_addr   = a;
        d_f3     = f3;
        d_wdata  = wd;
        d_rready = 1'b0;
        chk("req_ready_idle", {31'd0, o_qr}, 32'd1);
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        n = 1;
        while (!o_rv && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, lat(s) + 1);
        chk("rdata", o_rd, er);
        chk("err", {31'd0, o_err}, {31'd0, ee});
        rd = o_rd;
        for (int h = 0; h < hold; h++) begin
            d_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, o_rv}, 32'd1);
            chk("hold_rdata", o_rd, er);
            chk("hold_err", {31'd0, o_err}, {31'd0, ee});
            chk("hold_req_ready", {31'd0, o_qr}, 32'd0);
        end
        d_valid  = 1'b0;
        d_rready = 1'b1;
        @(posedge clk);
        #1;
        d_rready = 1'b0;
        chk("post_valid", {31'd0, o_rv}, 32'd0);
        chk("post_req_ready", {31'd0, o_qr}, 32'd1);
    endtask

    logic [31:0] rd;
    logic        ee;

    initial begin
        rst = 1'b1;
        sel = 0;
        d_valid = 0; d_write = 0; d_addr = 0; d_f3 = 0; d_wdata = 0; d_rready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, o_rv}, 32'd0);
        chk("rst_ready", {31'd0, o_qr}, 32'd1);
        chk("rst_rdata", o_rd, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        rst = 1'b0;

        for (int s = 0; s < 2; s++) begin
            xact(s, 1, 32'h10, 3'b010, 32'h8040_C0FF, 0, rd, ee);
            xact(s, 0, 32'h10, 3'b010, 0, 0, rd, ee);
            chk("plan_lw", rd, 32'h8040_C0FF);
            xact(s, 0, 32'h13, 3'b000, 0, 0, rd, ee);
            chk("plan_lb", rd, 32'hFFFF_FF80);
            xact(s, 0, 32'h13, 3'b100, 0, 0, rd, ee);
            chk("plan_lbu", rd, 32'h0000_0080);
            xact(s, 0, 32'h10, 3'b001, 0, 0, rd, ee);
            chk("plan_lh", rd, 32'hFFFF_C0FF);
            xact(s, 0, 32'h12, 3'b101, 0, 0, rd, ee);
            chk("plan_lhu", rd, 32'h0000_8040);
            xact(s, 1, 32'h11, 3'b000, 32'h0000_00AA, 0, rd, ee);
            xact(s, 0, 32'h10, 3'b010, 0, 0, rd, ee);
            chk("plan_sb_merge", rd, 32'h8040_AAFF);
            xact(s, 0, 32'h11, 3'b001, 0, 0, rd, ee);
            chk("plan_lh_mis", {31'd0, ee}, 32'd1);
            xact(s, 0, 32'h12, 3'b010, 0, 0, rd, ee);
            chk("plan_lw_mis", {31'd0, ee}, 32'd1);
            xact(s, 0, 32'h10, 3'b011, 0, 0, rd, ee);
            chk("plan_bad_f3", {31'd0, ee}, 32'd1);
            xact(s, 1, 32'(4 * dep(s)), 3'b010, 32'hDEAD_BEEF, 0, rd, ee);
            chk("plan_oor", {31'd0, ee}, 32'd1);
            xact(s, 1, 32'h14, 3'b011, 32'h1111_1111, 0, rd, ee);
            xact(s, 0, 32'h10, 3'b010, 0, 5, rd, ee);
            chk("plan_unchanged", rd, 32'h8040_AAFF);
        end

        // Store interrupted by reset during BUSY, then reset during RESP.
        xact(0, 1, 32'h20, 3'b010, 32'h0BAD_F00D, 0, rd, ee);
        sel = 0;
        @(negedge clk);
        d_valid = 1; d_write = 1; d_addr = 32'h20; d_f3 = 3'b010; d_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        d_valid = 0;
        chk("busy_valid", {31'd0, o_rv}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rbusy_valid", {31'd0, o_rv}, 32'd0);
        chk("rbusy_ready", {31'd0, o_qr}, 32'd1);
        chk("rbusy_rdata", o_rd, 32'd0);
        chk("rbusy_err", {31'd0, o_err}, 32'd0);
        @(posedge clk);
        #1;
        chk("rbusy_idle_valid", {31'd0, o_rv}, 32'd0);
        xact(0, 0, 32'h20, 3'b010, 0, 0, rd, ee);
        chk("dropped_store", rd, 32'h0BAD_F00D);

        @(negedge clk);
        d_valid = 1; d_write = 0; d_addr = 32'h10; d_f3 = 3'b010;
        @(posedge clk);
        #1;
        d_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("resp_before_rst", {31'd0, o_rv}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rresp_valid", {31'd0, o_rv}, 32'd0);
        chk("rresp_ready", {31'd0, o_qr}, 32'd1);
        chk("rresp_rdata", o_rd, 32'd0);

        // Random traffic over a window of initialised words plus out-of-range addresses.
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < ((s == 1) ? 16 : 10); w++) begin
                xact(s, 1, 32'(4 * w), 3'b010, $urandom, 0, rd, ee);
            end
            for (int k = 0; k < 60; k++) begin
                logic [31:0] a;
                if ($urandom_range(0, 7) == 0)
                    a = 32'(4 * dep(s)) + 32'($urandom_range(0, 7));
                else
                    a = 32'($urandom_range(0, (s == 1) ? 63 : 39));
                xact(s, 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)),
                     $urandom, int'($urandom_range(0, 1)), rd, ee);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
